alu_issue_stage: RTL and testbench

//  ID/EX issue stage of the pipelined core. Decodes a RISC-V instruction into the 4-bit ALU op code and selects ALU operands A/B.

---
 rtl/alu_issue_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : ID/EX issue stage. Decodes a RISC-V instruction into a 4-bit
//             ALU op code plus operands A/B, then holds the result in a
//             two-entry (main + skid) buffer behind a valid/ready handshake.
//             id_ready comes straight from a flop. Supports flush and keeps
//             a wrapping count of ops handed to EX.
//  Ports    : clk, rst_n (sync, active-low), flush
//             id_valid/id_ready, id_instr, id_pc, id_rs1_data, id_rs2_data
//             ex_valid/ex_ready, ex_alu_ctrl, ex_a, ex_b, ex_rs2_data,
//             ex_rd, ex_funct3, ex_is_branch, ex_illegal, issue_count
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_instr,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [3:0]       ex_alu_ctrl,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_is_branch,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] issue_count
);

    // ALU op codes
    localparam logic [3:0] c_ALU_AND   = 4'b0000;
    localparam logic [3:0] c_ALU_SLL   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD   = 4'b0010;
    localparam logic [3:0] c_ALU_SRL   = 4'b0011;
    localparam logic [3:0] c_ALU_XOR   = 4'b0100;
    localparam logic [3:0] c_ALU_SRA   = 4'b0101;
    localparam logic [3:0] c_ALU_SUB   = 4'b0110;
    localparam logic [3:0] c_ALU_SLT   = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU  = 4'b1000;
    localparam logic [3:0] c_ALU_OR    = 4'b1001;
    localparam logic [3:0] c_ALU_PASSB = 4'b1010;
    localparam logic [3:0] c_ALU_NOR   = 4'b1100;
    localparam logic [3:0] c_ALU_NAND  = 4'b1101;
    localparam logic [3:0] c_ALU_NOTA  = 4'b1110;
    localparam logic [3:0] c_ALU_CTZ   = 4'b1111;

    // Opcodes
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_CUST0  = 7'b0001011;

    typedef struct packed {
        logic            illegal;
        logic            is_branch;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] a;
        logic [3:0]      ctrl;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_iimm;
    logic [XLEN-1:0] w_simm;
    logic [XLEN-1:0] w_uimm;
    logic [XLEN-1:0] w_shamt;
    logic [3:0]      w_base_ctrl;
    entry_t          w_dec;

    assign w_opcode = id_instr[6:0];
    assign w_f3     = id_instr[14:12];
    assign w_f7     = id_instr[31:25];
    assign w_iimm   = XLEN'($signed(id_instr[31:20]));
    assign w_simm   = XLEN'($signed({id_instr[31:25], id_instr[11:7]}));
    assign w_uimm   = XLEN'($signed({id_instr[31:12], 12'b0}));
    assign w_shamt  = XLEN'(id_instr[24:20]);

    // funct3 -> op shared by register and immediate arithmetic forms
    always_comb begin
        w_base_ctrl = c_ALU_ADD;
        case (w_f3)
            3'b000:  w_base_ctrl = c_ALU_ADD;
            3'b001:  w_base_ctrl = c_ALU_SLL;
            3'b010:  w_base_ctrl = c_ALU_SLT;
            3'b011:  w_base_ctrl = c_ALU_SLTU;
            3'b100:  w_base_ctrl = c_ALU_XOR;
            3'b101:  w_base_ctrl = c_ALU_SRL;
            3'b110:  w_base_ctrl = c_ALU_OR;
            default: w_base_ctrl = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_dec           = '0;
        w_dec.rd        = id_instr[11:7];
        w_dec.funct3    = w_f3;
        w_dec.rs2_data  = id_rs2_data;
        w_dec.is_branch = (w_opcode == c_OP_BRANCH);
        w_dec.a         = id_rs1_data;
        w_dec.b         = id_rs2_data;
        w_dec.ctrl      = c_ALU_ADD;
        w_dec.illegal   = 1'b0;
        case (w_opcode)
            c_OP_REG: begin
                if (w_f7 == 7'b0000000)
                    w_dec.ctrl = w_base_ctrl;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b000)
                    w_dec.ctrl = c_ALU_SUB;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b101)
                    w_dec.ctrl = c_ALU_SRA;
                else
                    w_dec.illegal = 1'b1;
            end
            c_OP_IMM: begin
                // Immediate form has no SUB; instr[30] only selects SRA
                w_dec.ctrl = (w_f3 == 3'b101 && id_instr[30]) ? c_ALU_SRA : w_base_ctrl;
                w_dec.b    = (w_f3 == 3'b001 || w_f3 == 3'b101) ? w_shamt : w_iimm;
            end
            c_OP_LOAD:  w_dec.b = w_iimm;
            c_OP_STORE: w_dec.b = w_simm;
            c_OP_LUI: begin
                w_dec.ctrl = c_ALU_PASSB;
                w_dec.a    = '0;
                w_dec.b    = w_uimm;
            end
            c_OP_AUIPC: begin
                w_dec.a = id_pc;
                w_dec.b = w_uimm;
            end
            c_OP_JAL, c_OP_JALR: begin
                // ALU forms the link value pc+4
                w_dec.a = id_pc;
                w_dec.b = XLEN'(4);
            end
            c_OP_BRANCH: begin
                case (w_f3)
                    3'b000, 3'b001: w_dec.ctrl = c_ALU_SUB;
                    3'b100, 3'b101: w_dec.ctrl = c_ALU_SLT;
                    3'b110, 3'b111: w_dec.ctrl = c_ALU_SLTU;
                    default:        w_dec.illegal = 1'b1;
                endcase
            end
            c_OP_CUST0: begin
                case (w_f3)
                    3'b000:  w_dec.ctrl = c_ALU_NOR;
                    3'b001:  w_dec.ctrl = c_ALU_NAND;
                    3'b010:  w_dec.ctrl = c_ALU_NOTA;
                    3'b011:  w_dec.ctrl = c_ALU_CTZ;
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            // Every legal opcode ends in 2'b11, so a bad low pair lands here
            default: w_dec.illegal = 1'b1;
        endcase
        if (w_dec.illegal) begin
            w_dec.ctrl = c_ALU_AND;
            w_dec.a    = '0;
            w_dec.b    = '0;
        end
    end

    // ------------------------------------------------------------------
    // Main + skid buffer
    // ------------------------------------------------------------------
    entry_t          r_m;
    entry_t          r_s;
    logic            r_m_valid;
    logic            r_s_valid;
    logic            r_id_ready;
    logic [CNT_W-1:0] r_issue_count;

    logic w_accept;
    logic w_issue;
    logic w_m_free;
    logic w_m_valid_nxt;
    logic w_s_valid_nxt;
    logic w_m_load_s;
    logic w_m_load_in;
    logic w_s_load_in;

    assign w_accept = id_valid & r_id_ready;
    assign w_issue  = r_m_valid & ex_ready;
    // Main slot can take a new entry this cycle if empty or being drained
    assign w_m_free = ~r_m_valid | ex_ready;

    assign w_m_load_s    = w_m_free & r_s_valid;
    assign w_m_load_in   = w_m_free & ~r_s_valid & w_accept;
    // Incoming goes to skid when main is stalled, or when skid is moving up
    assign w_s_load_in   = w_accept & ~(w_m_free & ~r_s_valid);
    assign w_m_valid_nxt = w_m_free ? (r_s_valid | w_accept) : 1'b1;
    assign w_s_valid_nxt = w_m_free ? (r_s_valid & w_accept) : (r_s_valid | w_accept);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m           <= '0;
            r_s           <= '0;
            r_m_valid     <= 1'b0;
            r_s_valid     <= 1'b0;
            r_id_ready    <= 1'b1;
            r_issue_count <= '0;
        end else begin
            // A handshake completing in a flush cycle still counts
            if (w_issue)
                r_issue_count <= r_issue_count + CNT_W'(1);
            if (flush) begin
                r_m_valid  <= 1'b0;
                r_s_valid  <= 1'b0;
                r_id_ready <= 1'b1;
            end else begin
                if (w_m_load_s)
                    r_m <= r_s;
                else if (w_m_load_in)
                    r_m <= w_dec;
                if (w_s_load_in)
                    r_s <= w_dec;
                r_m_valid  <= w_m_valid_nxt;
                r_s_valid  <= w_s_valid_nxt;
                r_id_ready <= ~w_s_valid_nxt;
            end
        end
    end

    assign id_ready     = r_id_ready;
    assign ex_valid     = r_m_valid;
    assign ex_alu_ctrl  = r_m.ctrl;
    assign ex_a         = r_m.a;
    assign ex_b         = r_m.b;
    assign ex_rs2_data  = r_m.rs2_data;
    assign ex_rd        = r_m.rd;
    assign ex_funct3    = r_m.funct3;
    assign ex_is_branch = r_m.is_branch;
    assign ex_illegal   = r_m.illegal;
    assign issue_count  = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage. A queue-based model
//             (occupancy 0..2, front entry = what EX must see) plus a
//             table-driven decoder predict every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_rst_n, r_flush, r_id_valid, r_ex_ready;
    logic [31:0] r_instr, r_pc, r_rs1, r_rs2;

    logic        w_id_ready, w_ex_valid, w_br, w_ill;
    logic [3:0]  w_ctrl;
    logic [31:0] w_a, w_b, w_rs2, w_cnt;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;

    alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(r_rst_n), .flush(r_flush),
        .id_valid(r_id_valid), .id_ready(w_id_ready), .id_instr(r_instr),
        .id_pc(r_pc), .id_rs1_data(r_rs1), .id_rs2_data(r_rs2),
        .ex_valid(w_ex_valid), .ex_ready(r_ex_ready), .ex_alu_ctrl(w_ctrl),
        .ex_a(w_a), .ex_b(w_b), .ex_rs2_data(w_rs2), .ex_rd(w_rd),
        .ex_funct3(w_f3), .ex_is_branch(w_br), .ex_illegal(w_ill),
        .issue_count(w_cnt)
    );

    // Narrow-counter instance used to exercise counter wrap
    logic        r_w_rst_n = 1'b0;
    logic        r_w_valid = 1'b0;
    logic        r_w_ready = 1'b0;
    logic        w_w_id_ready, w_w_ex_valid, w_w_br, w_w_ill;
    logic [3:0]  w_w_ctrl;
    logic [31:0] w_w_a, w_w_b, w_w_rs2;
    logic [4:0]  w_w_rd;
    logic [2:0]  w_w_f3;
    logic [2:0]  w_w_cnt;

    alu_issue_stage #(.XLEN(32), .CNT_W(3)) dut_wrap (
        .clk(clk), .rst_n(r_w_rst_n), .flush(1'b0),
        .id_valid(r_w_valid), .id_ready(w_w_id_ready), .id_instr(32'h002081B3),
        .id_pc(32'h0), .id_rs1_data(32'h1), .id_rs2_data(32'h2),
        .ex_valid(w_w_ex_valid), .ex_ready(r_w_ready), .ex_alu_ctrl(w_w_ctrl),
        .ex_a(w_w_a), .ex_b(w_w_b), .ex_rs2_data(w_w_rs2), .ex_rd(w_w_rd),
        .ex_funct3(w_w_f3), .ex_is_branch(w_w_br), .ex_illegal(w_w_ill),
        .issue_count(w_w_cnt)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a, b, rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        br, ill;
    } exp_t;

    // funct3 -> op for register/immediate arithmetic
    localparam logic [3:0] RTAB [8] = '{4'd2, 4'd1, 4'd7, 4'd8, 4'd4, 4'd3, 4'd9, 4'd0};
    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17,
                                        7'h6F, 7'h67, 7'h63, 7'h0B, 7'h7F};

    exp_t        q[$];
    logic [31:0] m_cnt = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] iimm, simm, uimm;
        f3   = ins[14:12];
        f7   = ins[31:25];
        iimm = {{20{ins[31]}}, ins[31:20]};
        simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        uimm = {ins[31:12], 12'h000};
        e.rs2 = rs2; e.rd = ins[11:7]; e.f3 = f3; e.br = (ins[6:0] == 7'h63);
        e.ill = 1'b0; e.ctrl = 4'd2; e.a = rs1; e.b = rs2;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00)                  e.ctrl = RTAB[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = 4'd6;
                else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 4'd5;
                else                              e.ill = 1'b1;
            end
            7'h13: begin
                e.ctrl = (f3 == 3'd5 && ins[30]) ? 4'd5 : RTAB[f3];
                e.b    = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : iimm;
            end
            7'h03: e.b = iimm;
            7'h23: e.b = simm;
            7'h37: begin e.ctrl = 4'd10; e.a = 0; e.b = uimm; end
            7'h17: begin e.a = pc; e.b = uimm; end
            7'h6F, 7'h67: begin e.a = pc; e.b = 32'd4; end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
                else if (f3 < 3'd2)           e.ctrl = 4'd6;
                else if (f3 < 3'd6)           e.ctrl = 4'd7;
                else                          e.ctrl = 4'd8;
            end
            7'h0B: begin
                if (f3 < 3'd4) e.ctrl = 4'd12 + {1'b0, f3[1:0]};
                else           e.ill = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin e.ctrl = 0; e.a = 0; e.b = 0; end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic rdy, input logic fl, input logic rn);
        r_id_valid = v;  r_instr = ins; r_pc = $urandom; r_rs1 = rs1; r_rs2 = rs2;
        r_ex_ready = rdy; r_flush = fl; r_rst_n = rn;
    endtask

    // Advance one clock, update the model with the inputs seen at the edge, check outputs
    task automatic tick();
        logic hs_out, acc;
        @(posedge clk);
        if (!r_rst_n) begin
            q.delete();
            m_cnt = '0;
        end else begin
            hs_out = (q.size() > 0) && r_ex_ready;
            acc    = r_id_valid && (q.size() < 2);
            if (hs_out) m_cnt = m_cnt + 1;
            if (r_flush) q.delete();
            else begin
                if (hs_out) void'(q.pop_front());
                if (acc) q.push_back(ref_decode(r_instr, r_pc, r_rs1, r_rs2));
            end
        end
        #1;
        chk("ex_valid", w_ex_valid, q.size() > 0);
        chk("id_ready", w_id_ready, q.size() < 2);
        chk("issue_count", w_cnt, m_cnt);
        if (q.size() > 0) begin
            chk("alu_ctrl", w_ctrl, q[0].ctrl);
            chk("ex_a", w_a, q[0].a);
            chk("ex_b", w_b, q[0].b);
            chk("rs2_data", w_rs2, q[0].rs2);
            chk("rd", w_rd, q[0].rd);
            chk("funct3", w_f3, q[0].f3);
            chk("is_branch", w_br, q[0].br);
            chk("illegal", w_ill, q[0].ill);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          sel;
        ins      = $urandom;
        ins[6:0] = OPS[$urandom_range(0, 10)];
        sel      = $urandom_range(0, 3);
        if (sel == 0)      ins[31:25] = 7'h00;
        else if (sel == 1) ins[31:25] = 7'h20;
        if ($urandom_range(0, 15) == 0) ins[1:0] = 2'($urandom_range(0, 2));
        return ins;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] cnt_before;
        int          wexp;
        logic        hs;

        // Reset
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        drive(0, 0, 0, 0, 1, 0, 1);
        chk("rst_ex_valid", w_ex_valid, 0);
        chk("rst_id_ready", w_id_ready, 1);
        chk("rst_count", w_cnt, 0);
        chk("rst_ctrl", w_ctrl, 0);
        chk("rst_a", w_a, 0);
        chk("rst_b", w_b, 0);
        chk("rst_illegal", w_ill, 0);

        // ADD x3,x1,x2
        drive(1, 32'h002081B3, 5, 7, 1, 0, 1);
        tick();
        chk("t1_valid", w_ex_valid, 1);
        chk("t1_ctrl", w_ctrl, 4'b0010);
        chk("t1_a", w_a, 5);
        chk("t1_b", w_b, 7);
        chk("t1_rd", w_rd, 3);
        drive(0, 0, 0, 0, 1, 0, 1);
        tick();
        chk("t1_count", w_cnt, 1);

        // SRAI and LUI
        drive(1, 32'h40335293, 32'hF0000000, 0, 1, 0, 1);
        tick();
        chk("t2_srai_ctrl", w_ctrl, 4'b0101);
        chk("t2_srai_b", w_b, 3);
        drive(1, 32'h123450B7, 9, 9, 1, 0, 1);
        tick();
        chk("t2_lui_ctrl", w_ctrl, 4'b1010);
        chk("t2_lui_a", w_a, 0);
        chk("t2_lui_b", w_b, 32'h12345000);

        // custom-0 CTZ, then an illegal opcode
        drive(1, 32'h0000300B, 32'h00000080, 0, 1, 0, 1);
        tick();
        chk("t5_ctz_ctrl", w_ctrl, 4'b1111);
        chk("t5_ctz_a", w_a, 32'h80);
        drive(1, 32'h0000007F, 32'h1234, 32'h5678, 1, 0, 1);
        tick();
        chk("t5_ill", w_ill, 1);
        chk("t5_ill_ctrl", w_ctrl, 0);
        chk("t5_ill_a", w_a, 0);
        chk("t5_ill_b", w_b, 0);
        drive(0, 0, 0, 0, 1, 0, 1);
        tick();

        // Back-pressure: three back-to-back, EX stalled
        drive(1, 32'h002080B3, 1, 1, 0, 0, 1); tick();
        drive(1, 32'h00208133, 2, 2, 0, 0, 1); tick();
        chk("t3_id_ready", w_id_ready, 0);
        drive(1, 32'h002081B3, 3, 3, 0, 0, 1); tick(); tick();
        chk("t3_hold_rd", w_rd, 1);
        drive(1, 32'h002081B3, 3, 3, 1, 0, 1); tick();
        chk("t3_second_rd", w_rd, 2);
        tick();
        drive(0, 0, 0, 0, 1, 0, 1);
        tick();
        chk("t3_third_rd", w_rd, 3);
        tick();

        // Flush with both entries full
        drive(1, 32'h00208133, 4, 4, 0, 0, 1); tick();
        drive(1, 32'h002081B3, 5, 5, 0, 0, 1); tick();
        cnt_before = m_cnt;
        drive(1, 32'h002080B3, 6, 6, 0, 1, 1); tick();
        chk("t4_valid", w_ex_valid, 0);
        chk("t4_id_ready", w_id_ready, 1);
        chk("t4_count", w_cnt, cnt_before);

        // Reset mid-operation
        drive(1, 32'h00208133, 4, 4, 0, 0, 1); tick();
        drive(1, 32'h002081B3, 5, 5, 0, 0, 1); tick();
        drive(1, 32'h002081B3, 5, 5, 1, 0, 0); tick();
        chk("t6_valid", w_ex_valid, 0);
        chk("t6_id_ready", w_id_ready, 1);
        chk("t6_count", w_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 99) != 0);
            tick();
        end

        // Counter wrap on the 3-bit instance
        r_w_rst_n = 1'b1; r_w_valid = 1'b1; r_w_ready = 1'b1;
        wexp = 0;
        for (int i = 0; i < 12; i++) begin
            hs = w_w_ex_valid;
            @(posedge clk);
            #1;
            if (hs) begin
                if (wexp == 7) begin
                    wexp = 0;
                    chk("wrap_to_zero", w_w_cnt, 0);
                end else begin
                    wexp = wexp + 1;
                    chk("wrap_count", w_w_cnt, wexp);
                end
            end else begin
                chk("wrap_idle", w_w_cnt, wexp);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
